// File: rtl/call_stack_pkg.sv
// Shared CPU constants for the return-address stack: default PC width, default depth,
// and the pointer-width helper.
package cpu_pkg;
  localparam int PC_W        = 10;
  localparam int STACK_DEPTH = 8;

  function automatic int ptr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction
endpackage

// File: rtl/call_stack_if.sv
// Call/return bus between the PC logic (master) and the return-address stack (slave).
interface call_stack_if
  import cpu_pkg::*;
#(
  parameter int WIDTH = PC_W,
  parameter int DEPTH = STACK_DEPTH
);
  localparam int PW = ptr_w(DEPTH);

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] din;
  logic             err_clr;
  logic [WIDTH-1:0] top;
  logic [PW:0]      count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  modport master (output push, pop, din, err_clr,
                  input  top, count, empty, full, overflow, underflow);
  modport slave  (input  push, pop, din, err_clr,
                  output top, count, empty, full, overflow, underflow);
endinterface

// File: rtl/call_stack_mem.sv
// Return-address storage: one synchronous write port, one asynchronous read port,
// contents deliberately left unreset.
module stack_mem #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/call_stack.sv
// Parametrised return-address stack: head pointer, count, full policy and sticky
// error flags; top-of-stack is readable combinationally in the cycle of a pop.
module call_stack
  import cpu_pkg::*;
#(
  parameter int WIDTH        = PC_W,
  parameter int DEPTH        = STACK_DEPTH,
  parameter int WRAP_ON_FULL = 0
) (
  input  logic         clk,
  input  logic         reset,
  call_stack_if.slave  bus
);
  localparam int PW = ptr_w(DEPTH);
  localparam bit WRAP = (WRAP_ON_FULL != 0);
  localparam logic [PW-1:0] HP_LAST = PW'(DEPTH - 1);
  localparam logic [PW:0]   CNT_MAX = (PW + 1)'(DEPTH);

  logic [PW-1:0]    hp, hp_nx, hp_inc, hp_dec, waddr;
  logic [PW:0]      count_q, cnt_nx;
  logic             we, ovf_evt, udf_evt, empty, full, overflow, underflow;
  logic [WIDTH-1:0] rd_data;

  // DEPTH need not be a power of two, so wrap by compare rather than masking
  assign hp_inc = (hp == HP_LAST) ? '0 : hp + 1'b1;
  assign hp_dec = (hp == '0) ? HP_LAST : hp - 1'b1;
  assign empty  = (count_q == '0);
  assign full   = (count_q == CNT_MAX);

  always_comb begin
    we      = 1'b0;
    waddr   = hp;
    hp_nx   = hp;
    cnt_nx  = count_q;
    ovf_evt = 1'b0;
    udf_evt = 1'b0;
    if (bus.push && bus.pop && !empty) begin
      // call immediately replacing a return: overwrite top in place
      we    = 1'b1;
      waddr = hp_dec;
    end else if (bus.push) begin
      if (!full || WRAP) begin
        we    = 1'b1;
        hp_nx = hp_inc;
      end
      if (!full) cnt_nx = count_q + 1'b1;
      else       ovf_evt = 1'b1;
    end else if (bus.pop) begin
      if (!empty) begin
        hp_nx  = hp_dec;
        cnt_nx = count_q - 1'b1;
      end else begin
        udf_evt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hp        <= '0;
      count_q   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      hp        <= hp_nx;
      count_q   <= cnt_nx;
      // a new error in the clearing cycle wins over err_clr
      overflow  <= (overflow  & ~bus.err_clr) | ovf_evt;
      underflow <= (underflow & ~bus.err_clr) | udf_evt;
    end
  end

  stack_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(PW)) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (bus.din),
    .raddr (hp_dec),
    .rdata (rd_data)
  );

  assign bus.top       = empty ? '0 : rd_data;
  assign bus.count     = count_q;
  assign bus.empty     = empty;
  assign bus.full      = full;
  assign bus.overflow  = overflow;
  assign bus.underflow = underflow;
endmodule
